muxn_rr_reg: RTL

- Parametrised successor to the two-input combinational mux: N input channels of WIDTH bits, each with a valid/ready handshake.
- Channels are merged onto one registered output stream.
- Selection is either fixed by a select input, matching legacy mux behaviour, or round-robin arbitrated across valid channels.
- Sits between multiple producers and a single consumer in the datapath.

---
 rtl/muxn_rr_reg.sv | 109 ++++++++++
 1 files changed

// File: rtl/muxn_rr_reg.sv
// N-channel valid/ready merge onto one registered output, with fixed-select
// or round-robin channel choice.
module muxn_rr_reg #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 4,
    localparam int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int              SELW1     = SELW + 1;
    localparam logic [SELW:0]   NUM_IN_W  = SELW1'(NUM_IN);
    localparam logic [SELW-1:0] LAST_CH   = SELW'(NUM_IN - 1);

    logic [SELW-1:0]   last_grant;
    logic [NUM_IN-1:0] fix_grant;
    logic [NUM_IN-1:0] rr_grant;
    logic [NUM_IN-1:0] grant;
    logic [WIDTH-1:0]  sel_data;
    logic [SELW-1:0]   sel_src;
    logic              load_en;
    logic              transfer;

    // Handshake: a word moves on any edge where valid and ready are both high;
    // producers hold valid/data until ready, and the output register may load a
    // new word on the same edge the consumer drains the old one.
    assign load_en = !out_valid || out_ready;

    always_comb begin
        fix_grant = '0;
        if ({1'b0, sel} < NUM_IN_W) begin
            fix_grant[sel] = in_valid[sel];
        end
    end

    // Search starts one past the last RR winner and wraps, so every valid
    // channel is reached within NUM_IN grants.
    always_comb begin
        int              idx;
        logic            found;
        logic [SELW-1:0] idx_s;
        idx      = 0;
        idx_s    = '0;
        found    = 1'b0;
        rr_grant = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            idx_s = SELW'(idx);
            if (!found && in_valid[idx_s]) begin
                rr_grant[idx_s] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    assign grant    = mode ? rr_grant : fix_grant;
    assign in_ready = grant & {NUM_IN{load_en}};
    assign transfer = |(in_valid & in_ready);

    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_src  = SELW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load_en) begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= sel_src;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Fixed-mode traffic leaves the pointer alone so RR resumes where it left off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= LAST_CH;
        end else if (transfer && mode) begin
            last_grant <= sel_src;
        end
    end

endmodule
